// File: rtl/arith_pkg.sv
// Shared arithmetic datapath types: divider state encoding and counter sizing.
// The divider's optional two's-complement mode is selected by DIV_SIGNED_EN.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_N_DEFAULT = 4;

  // Iteration counter width for an n-bit divide.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/add_sub.sv
// Ripple-carry adder-subtractor: sum = a + b (ctrl=0) or a - b (ctrl=1).
module add_sub #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ctrl,
  output logic [W-1:0] sum
);

  logic [W-1:0] b_x;
  logic [W-1:0] carry;

  assign b_x      = b ^ {W{ctrl}};
  assign carry[0] = ctrl;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum[i] = a[i] ^ b_x[i] ^ carry[i];
    if (i < W - 1) begin : g_carry
      assign carry[i+1] = (a[i] & b_x[i]) | (carry[i] & (a[i] ^ b_x[i]));
    end
  end

endmodule

// File: rtl/div_restoring.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define DIV_SIGNED_EN for two's-complement operands (truncation toward zero).
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// CALC  | one trial subtraction per cycle, N cycles
// DONE  | result held on outputs until out_ready
module div_restoring
  import arith_pkg::*;
#(
  parameter int N = DIV_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_zero
);

  localparam int CW = cnt_width(N);

  div_state_t    state, state_nxt;
  logic [N-1:0]  r_q, q_q, d_q;
  logic [CW-1:0] cnt_q;
  logic [N:0]    trial;
  logic [N-1:0]  r_nxt, q_nxt, q_fin, r_fin;
  logic [N-1:0]  dvd_mag, dvs_mag;
  logic          accept, zero_div, last_iter;

  assign accept    = (state == IDLE) && in_valid;
  assign zero_div  = (divisor == '0);
  assign last_iter = (cnt_q == CW'(N - 1));

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;

  assign dvd_mag = dividend[N-1] ? (~dividend + 1'b1) : dividend;
  assign dvs_mag = divisor[N-1]  ? (~divisor + 1'b1)  : divisor;
  assign q_fin   = neg_q ? (~q_nxt + 1'b1) : q_nxt;
  assign r_fin   = neg_r ? (~r_nxt + 1'b1) : r_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= dividend[N-1] ^ divisor[N-1];
      neg_r <= dividend[N-1];
    end
  end
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_fin   = q_nxt;
  assign r_fin   = r_nxt;
`endif

  // Operand a is {R,Q} shifted left by one, seen through its upper N+1 bits.
  add_sub #(.W(N + 1)) u_trial (
    .a   ({r_q, q_q[N-1]}),
    .b   ({1'b0, d_q}),
    .ctrl(1'b1),
    .sum (trial)
  );

  always_comb begin
    r_nxt = {r_q[N-2:0], q_q[N-1]};
    q_nxt = {q_q[N-2:0], 1'b0};
    if (!trial[N]) begin
      r_nxt = trial[N-1:0];
      q_nxt = {q_q[N-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = zero_div ? DONE : CALC;
      end
      CALC: if (last_iter) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      r_q   <= '0;
      q_q   <= dvd_mag;
      d_q   <= dvs_mag;
      cnt_q <= '0;
      if (zero_div) begin
        quotient  <= '1;
        remainder <= dividend;
        div_zero  <= 1'b1;
      end
    end else if (state == CALC) begin
      r_q   <= r_nxt;
      q_q   <= q_nxt;
      cnt_q <= cnt_q + 1'b1;
      if (last_iter) begin
        quotient  <= q_fin;
        remainder <= r_fin;
        div_zero  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_restoring.sv
// Self-checking bench for div_restoring (N=4); signed cases run when DIV_SIGNED_EN is defined.
module tb_div_restoring;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_zero;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  div_restoring #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division on the operand values.
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] q, output logic [N-1:0] r,
                                output logic z);
    int sa, sb;
    if (b == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
`else
      sa = int'(a);
      sb = int'(b);
`endif
      q = N'(sa / sb);
      r = N'(sa % sb);
      z = 1'b0;
    end
  endfunction

  // One transaction; stall = cycles out_ready is held low once the result appears.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input int stall, output int acc_cyc);
    logic [N-1:0] eq, er;
    logic         ez;
    int           n;
    model(a, b, eq, er, ez);
    out_ready = (stall == 0);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("wait_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("latency_edges", 32'(n), (b == 0) ? 32'd0 : 32'(N));
    chk("quotient", 32'(quotient), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
    chk("div_zero", 32'(div_zero), 32'(ez));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_quotient", 32'(quotient), 32'(eq));
      chk("stall_remainder", 32'(remainder), 32'(er));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_xfer_out_valid", 32'(out_valid), 32'd0);
    chk("post_xfer_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int acc1, acc2;
    logic [N-1:0] ra, rb;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);

`ifdef DIV_SIGNED_EN
    run_op(4'b1001, 4'd2, 0, acc1);
    chk("s_neg7_div2_q", 32'(quotient), 32'(4'b1101));
    run_op(4'b1000, 4'b1111, 0, acc1);
    chk("s_neg8_divneg1_q", 32'(quotient), 32'(4'b1000));
    chk("s_neg8_divneg1_r", 32'(remainder), 32'd0);
`endif

    run_op(4'd13, 4'd3, 0, acc1);
    run_op(4'd7, 4'd0, 0, acc1);
    chk("div0_quotient_all_ones", 32'(quotient), 32'd15);

    run_op(4'd15, 4'd1, 0, acc1);
    run_op(4'd3, 4'd5, 0, acc2);
    chk("init_interval", 32'(acc2 - acc1), 32'(N + 2));

    run_op(4'd9, 4'd2, 5, acc1);

    // Reset two cycles into CALC discards the in-flight divide.
    in_valid = 1'b1;
    dividend = 4'd14;
    divisor  = 4'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midcalc_rst_in_ready", 32'(in_ready), 32'd1);
    chk("midcalc_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midcalc_rst_quotient", 32'(quotient), 32'd0);
    chk("midcalc_rst_remainder", 32'(remainder), 32'd0);
    chk("midcalc_rst_div_zero", 32'(div_zero), 32'd0);
    run_op(4'd14, 4'd3, 0, acc1);

    for (int i = 0; i < 24; i++) begin
      ra = N'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      run_op(ra, rb, int'($urandom_range(0, 2)), acc1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
